ccip_async_c0_credit_ctrl: RTL and testbench
============================================

Name: ccip_async_c0_credit_ctrl

Overview:
Read-request flow-control stage for the async CCI-P shim. It consumes the c0 outstanding-line count and the buffered-response occupancy, and produces the registered c0TxAlmFull sent to the AFU. Its purpose is to stop the response buffer from overflowing. It also polices the CCI-P post-almFull slack rule: at most SLACK requests may be issued after almFull asserts.

Parameters:
C0RX_DEPTH_RADIX, 10, log2 of response buffer capacity in lines (CAP = 2**RADIX)
SLACK, 8, requests the AFU may legally issue after almFull asserts
HYST, 4, lines of hysteresis above RESERVE required before almFull deasserts

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
c0Tx  in  t_if_ccip_c0_Tx  AFU read request, same cycle it enters the shim
active_cnt  in  C0RX_DEPTH_RADIX  lines requested but not yet returned by FIU
rsp_fifo_used  in  C0RX_DEPTH_RADIX+1  lines buffered, not yet delivered to AFU
fiu_almFull  in  1  c0TxAlmFull from FIU side, already synchronized
c0TxAlmFull  out  1  registered almost-full to AFU
slack_used  out  4  requests accepted since almFull asserted
err_overflow  out  1  sticky: slack exceeded, or committed > CAP

Behaviour:
- Clock and reset: clk; reset is reset, synchronous, active-high.
- Reset values: c0TxAlmFull=1, slack_used=0, err_overflow=0, state=CLOSING.
  - Reset mid-operation returns to these values on the next edge regardless of inputs.
- Combinational terms, all width RADIX+2, no wrap:
  - committed = active_cnt + rsp_fifo_used
  - avail = (committed >= CAP) ? 0 : CAP - committed
  - RESERVE = SLACK*4 (4 = max lines per request)
  - req_lines = c0Tx.valid ? 1 + cl_len : 0
  - committed > CAP sets err_overflow.
- FSM states: OPEN, CLOSING, CLOSED. c0TxAlmFull = (state != OPEN), registered.
- OPEN:
  - Go to CLOSING if fiu_almFull, or if (avail - req_lines) <= RESERVE. The current request is subtracted in the same cycle.
  - slack_used held at 0.
- CLOSING:
  - Each c0Tx.valid increments slack_used; saturates at 15.
  - Go to CLOSED when slack_used reaches SLACK.
  - Go to OPEN when !fiu_almFull && avail >= RESERVE+HYST && !c0Tx.valid. slack_used clears on this transition.
- CLOSED:
  - Any c0Tx.valid sets err_overflow. slack_used still counts (saturating).
  - Same exit condition to OPEN as CLOSING.
- Simultaneous events:
  - Close condition and a request in the same OPEN cycle: the request is not counted as slack, because almFull was not yet visible to the AFU.
  - Open condition and a request in the same cycle: exit is blocked for that cycle.
- Latency: inputs to c0TxAlmFull is 1 cycle.
- err_overflow clears only on reset.
- Boundary cases:
  - avail == RESERVE closes.
  - avail == RESERVE+HYST-1 stays closed.
  - committed == CAP gives avail = 0 with no error.

Optional Feature:
CCIP_ASYNC_CREDIT_STATS_EN
- Defined: adds outputs stat_peak_committed (RADIX+1 bits, max committed since reset) and stat_closed_cycles (32 bits, counts cycles with c0TxAlmFull=1, saturating). Both reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package ccip_async_pkg holds:
  - enum t_credit_state {OPEN, CLOSING, CLOSED}
  - localparam CCIP_MAX_LINES_PER_REQ = 4
  - function lines_of_req(cl_len) returning 1+cl_len
- One sub-module, ccip_async_credit_fsm: the state register, slack counter and err logic. It takes avail, req_lines and fiu_almFull.
- The top level computes committed/avail and holds the optional stats.

Test Plan:
All scenarios use RADIX=6 (CAP=64), SLACK=8 (RESERVE=32), HYST=4.
1. Reset released with active_cnt=0, fifo_used=0 → almFull=1 in cycle 0, almFull=0 one cycle later (avail 64 ≥ 36).
2. active_cnt=28, 4-line request issued → avail-req=32 ≤ 32 → almFull=1 next cycle; slack_used stays 0.
3. Enter CLOSING, then issue 8 single-line requests → slack_used=8, state CLOSED, err=0; a 9th request → err_overflow=1 and remains 1.
4. Closed, committed drops to 29 (avail 35) → almFull stays 1; committed drops to 28 (avail 36) with no request → almFull=0 next cycle, slack_used=0.
5. avail=50 and fiu_almFull pulsed high for 1 cycle → almFull=1 next cycle; deasserts the cycle after fiu_almFull drops.
6. active_cnt=40, fifo_used=30 (committed 70 > 64) → err_overflow=1 and avail treated as 0 (almFull=1); assert reset mid-CLOSED → all outputs return to reset values next edge.

Source files
------------

// File: rtl/ccip_async_pkg.sv
// Shared types and helpers for the async CCI-P shim c0 credit logic.
package ccip_async_pkg;

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    CLOSING = 2'd1,
    CLOSED  = 2'd2
  } t_credit_state;

  localparam int CCIP_MAX_LINES_PER_REQ = 4;

  typedef logic [1:0] t_ccip_clLen;

  // Reduced c0 request header: only the fields the credit logic consumes.
  typedef struct packed {
    logic        valid;
    t_ccip_clLen cl_len;
  } t_if_ccip_c0_Tx;

  function automatic logic [2:0] lines_of_req(input t_ccip_clLen cl_len);
    return 3'd1 + {1'b0, cl_len};
  endfunction

endpackage

// File: rtl/ccip_async_credit_fsm.sv
// Credit FSM: OPEN/CLOSING/CLOSED state, post-almFull slack counter and
// sticky overflow flag. All outputs are registered.
module ccip_async_credit_fsm
  import ccip_async_pkg::*;
#(
  parameter int W     = 12,
  parameter int SLACK = 8,
  parameter int HYST  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] avail,
  input  logic [W-1:0] req_lines,
  input  logic         req_valid,
  input  logic         fiu_almFull,
  input  logic         overcommit,
  output logic         c0TxAlmFull,
  output logic [3:0]   slack_used,
  output logic         err_overflow
);

  localparam logic [W-1:0] RESERVE      = W'(SLACK * CCIP_MAX_LINES_PER_REQ);
  localparam logic [W-1:0] OPEN_THRESH  = W'(SLACK * CCIP_MAX_LINES_PER_REQ + HYST);
  localparam logic [3:0]   SLACK_LIMIT  = 4'(SLACK);

  t_credit_state state_q, state_d;
  logic          almfull_q, almfull_d;
  logic [3:0]    slack_q, slack_d;
  logic          err_q, err_d;
  logic [3:0]    slack_inc;
  logic          open_ok;
  logic          close_now;

  // Next-state, slack and error computation.
  always_comb begin
    state_d   = state_q;
    slack_d   = slack_q;
    err_d     = err_q | overcommit;
    slack_inc = (slack_q == 4'd15) ? slack_q : slack_q + 4'd1;
    // A request in the same cycle blocks reopening.
    open_ok   = !fiu_almFull && (avail >= OPEN_THRESH) && !req_valid;
    // The in-flight request is charged against avail before comparing.
    close_now = fiu_almFull || (avail <= RESERVE + req_lines);

    case (state_q)
      OPEN: begin
        slack_d = 4'd0;
        if (close_now) begin
          state_d = CLOSING;
        end else begin
          state_d = OPEN;
        end
      end
      CLOSING: begin
        if (open_ok) begin
          state_d = OPEN;
          slack_d = 4'd0;
        end else begin
          slack_d = req_valid ? slack_inc : slack_q;
          state_d = (slack_d >= SLACK_LIMIT) ? CLOSED : CLOSING;
        end
      end
      CLOSED: begin
        if (open_ok) begin
          state_d = OPEN;
          slack_d = 4'd0;
        end else begin
          state_d = CLOSED;
          slack_d = req_valid ? slack_inc : slack_q;
          if (req_valid) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q | overcommit;
          end
        end
      end
      default: begin
        state_d = CLOSING;
        slack_d = 4'd0;
      end
    endcase

    almfull_d = (state_d != OPEN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLOSING;
      almfull_q <= 1'b1;
      slack_q   <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      almfull_q <= almfull_d;
      slack_q   <= slack_d;
      err_q     <= err_d;
    end
  end

  assign c0TxAlmFull  = almfull_q;
  assign slack_used   = slack_q;
  assign err_overflow = err_q;

endmodule

// File: rtl/ccip_async_c0_credit_ctrl.sv
// c0 read-request flow control: produces c0TxAlmFull from committed lines.
// Optional stats outputs enabled by CCIP_ASYNC_CREDIT_STATS_EN.
module ccip_async_c0_credit_ctrl
  import ccip_async_pkg::*;
#(
  parameter int C0RX_DEPTH_RADIX = 10,
  parameter int SLACK            = 8,
  parameter int HYST             = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  t_if_ccip_c0_Tx              c0Tx,
  input  logic [C0RX_DEPTH_RADIX-1:0] active_cnt,
  input  logic [C0RX_DEPTH_RADIX:0]   rsp_fifo_used,
  input  logic                        fiu_almFull,
  output logic                        c0TxAlmFull,
  output logic [3:0]                  slack_used,
  output logic                        err_overflow
`ifdef CCIP_ASYNC_CREDIT_STATS_EN
  ,
  output logic [C0RX_DEPTH_RADIX:0]   stat_peak_committed,
  output logic [31:0]                 stat_closed_cycles
`endif
);

  localparam int           W   = C0RX_DEPTH_RADIX + 2;
  localparam logic [W-1:0] CAP = W'(2 ** C0RX_DEPTH_RADIX);

  logic [W-1:0] committed;
  logic [W-1:0] avail;
  logic [W-1:0] req_lines;
  logic         overcommit;

  // Credit arithmetic; W bits hold the worst-case sum without wrapping.
  always_comb begin
    committed  = {2'b00, active_cnt} + {1'b0, rsp_fifo_used};
    avail      = (committed >= CAP) ? {W{1'b0}} : CAP - committed;
    req_lines  = c0Tx.valid ? W'(lines_of_req(c0Tx.cl_len)) : {W{1'b0}};
    overcommit = (committed > CAP);
  end

  ccip_async_credit_fsm #(
    .W     (W),
    .SLACK (SLACK),
    .HYST  (HYST)
  ) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .avail        (avail),
    .req_lines    (req_lines),
    .req_valid    (c0Tx.valid),
    .fiu_almFull  (fiu_almFull),
    .overcommit   (overcommit),
    .c0TxAlmFull  (c0TxAlmFull),
    .slack_used   (slack_used),
    .err_overflow (err_overflow)
  );

`ifdef CCIP_ASYNC_CREDIT_STATS_EN
  localparam logic [W-1:0] PEAK_MAX = W'((2 ** (C0RX_DEPTH_RADIX + 1)) - 1);

  logic [C0RX_DEPTH_RADIX:0] peak_q, peak_d;
  logic [31:0]               closed_q, closed_d;
  logic [W-1:0]              committed_sat;

  // Peak tracking saturates at the stat width; cycle counter saturates too.
  always_comb begin
    committed_sat = (committed > PEAK_MAX) ? PEAK_MAX : committed;
    if (committed_sat > {1'b0, peak_q}) begin
      peak_d = committed_sat[C0RX_DEPTH_RADIX:0];
    end else begin
      peak_d = peak_q;
    end
    if (c0TxAlmFull && (closed_q != 32'hFFFF_FFFF)) begin
      closed_d = closed_q + 32'd1;
    end else begin
      closed_d = closed_q;
    end
  end

  // Stats registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q   <= {(C0RX_DEPTH_RADIX + 1){1'b0}};
      closed_q <= 32'd0;
    end else begin
      peak_q   <= peak_d;
      closed_q <= closed_d;
    end
  end

  assign stat_peak_committed = peak_q;
  assign stat_closed_cycles  = closed_q;
`endif

endmodule

// File: tb/tb_ccip_async_c0_credit_ctrl.sv
// Bench for ccip_async_c0_credit_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_ccip_async_c0_credit_ctrl;
  import ccip_async_pkg::*;

  localparam int RADIX   = 6;
  localparam int SLACK   = 8;
  localparam int HYST    = 4;
  localparam int CAP     = 64;
  localparam int RESERVE = 32;

  logic           clk;
  logic           reset;
  t_if_ccip_c0_Tx c0Tx;
  logic [5:0]     active_cnt;
  logic [6:0]     rsp_fifo_used;
  logic           fiu_almFull;
  logic           c0TxAlmFull;
  logic [3:0]     slack_used;
  logic           err_overflow;
`ifdef CCIP_ASYNC_CREDIT_STATS_EN
  logic [6:0]     stat_peak_committed;
  logic [31:0]    stat_closed_cycles;
`endif

  int vectors;
  int miscompares;

  ccip_async_c0_credit_ctrl #(
    .C0RX_DEPTH_RADIX (RADIX),
    .SLACK            (SLACK),
    .HYST             (HYST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .c0Tx          (c0Tx),
    .active_cnt    (active_cnt),
    .rsp_fifo_used (rsp_fifo_used),
    .fiu_almFull   (fiu_almFull),
    .c0TxAlmFull   (c0TxAlmFull),
    .slack_used    (slack_used),
    .err_overflow  (err_overflow)
`ifdef CCIP_ASYNC_CREDIT_STATS_EN
    ,
    .stat_peak_committed (stat_peak_committed),
    .stat_closed_cycles  (stat_closed_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit   rst;
    bit   vld;
    int   len;
    int   a;
    int   f;
    bit   fiu;
    bit   e_alm;
    int   e_slack;
    bit   e_err;
    string name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit vld, input int len, input int a, input int f,
                     input bit fiu, input bit e_alm, input int e_slack, input bit e_err,
                     input string name);
    vec_t v;
    v.rst = rst; v.vld = vld; v.len = len; v.a = a; v.f = f; v.fiu = fiu;
    v.e_alm = e_alm; v.e_slack = e_slack; v.e_err = e_err; v.name = name;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs and sample outputs 1 time unit after the edge.
  task automatic step(input bit rst, input bit vld, input int len, input int a, input int f,
                      input bit fiu);
    reset         = rst;
    c0Tx.valid    = vld;
    c0Tx.cl_len   = 2'(len);
    active_cnt    = 6'(a);
    rsp_fifo_used = 7'(f);
    fiu_almFull   = fiu;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input bit e_alm, input int e_slack, input bit e_err);
    vectors++;
    if (c0TxAlmFull !== e_alm || int'(slack_used) != e_slack || err_overflow !== e_err) begin
      miscompares++;
      $display("FAIL %s: got alm=%0b slack=%0d err=%0b, expected alm=%0b slack=%0d err=%0b",
               name, c0TxAlmFull, slack_used, err_overflow, e_alm, e_slack, e_err);
    end
  endtask

  // Behavioural model: almFull is either asserted or not; once asserted the
  // AFU has SLACK requests of grace, and any beyond that is an error.
  bit m_alm;
  int m_slack;
  bit m_err;

  task automatic model(input bit rst, input bit vld, input int len, input int a, input int f,
                       input bit fiu);
    int committed, avail, lines;
    committed = a + f;
    avail     = (committed >= CAP) ? 0 : CAP - committed;
    lines     = vld ? 1 + len : 0;
    if (rst) begin
      m_alm = 1'b1; m_slack = 0; m_err = 1'b0;
    end else begin
      if (committed > CAP) m_err = 1'b1;
      if (!m_alm) begin
        if (fiu || (avail - lines) <= RESERVE) m_alm = 1'b1;
        m_slack = 0;
      end else if (!fiu && avail >= RESERVE + HYST && !vld) begin
        m_alm = 1'b0; m_slack = 0;
      end else if (vld) begin
        if (m_slack >= SLACK) m_err = 1'b1;
        m_slack = (m_slack + 1 > 15) ? 15 : m_slack + 1;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; c0Tx = '0; active_cnt = '0; rsp_fifo_used = '0; fiu_almFull = 1'b0;

    //  rst vld len  a   f  fiu  alm slk err
    add(1, 0, 0,  0,  0, 0,   1,  0, 0, "reset_values");
    add(0, 0, 0,  0,  0, 0,   0,  0, 0, "open_after_reset");
    add(0, 1, 3, 28,  0, 0,   1,  0, 0, "close_on_4line_req");
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 28, 0, 0,  1,  i, 0, "slack_count");
    add(0, 1, 0, 28,  0, 0,   1,  9, 1, "ninth_req_err");
    add(0, 0, 0, 29,  0, 0,   1,  9, 1, "avail35_stays_closed");
    add(0, 0, 0, 28,  0, 0,   0,  0, 1, "avail36_reopens");
    add(1, 0, 0, 28,  0, 0,   1,  0, 0, "reset_clears_err");
    add(0, 0, 0,  0,  0, 0,   0,  0, 0, "reopen2");
    add(0, 0, 0, 14,  0, 1,   1,  0, 0, "fiu_pulse_closes");
    add(0, 0, 0, 14,  0, 0,   0,  0, 0, "fiu_drop_reopens");
    add(0, 0, 0, 32,  0, 0,   1,  0, 0, "avail_eq_reserve_closes");
    add(0, 0, 0, 32,  0, 0,   1,  0, 0, "avail32_stays");
    add(0, 0, 0, 29,  0, 0,   1,  0, 0, "avail35_hyst_stays");
    add(0, 1, 0, 28,  0, 0,   1,  1, 0, "req_blocks_open");
    add(0, 0, 0, 28,  0, 0,   0,  0, 0, "open_after_block");
    add(0, 0, 0, 31,  0, 0,   0,  0, 0, "avail33_stays_open");
    add(0, 1, 0, 31,  0, 0,   1,  0, 0, "close_req_not_slack");
    add(0, 0, 0, 40, 24, 0,   1,  0, 0, "committed_eq_cap_no_err");
    add(0, 0, 0, 40, 30, 0,   1,  0, 1, "overcommit_err");
    add(1, 0, 0, 40, 30, 0,   1,  0, 0, "reset_mid_err");

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].len, tbl[i].a, tbl[i].f, tbl[i].fiu);
      chk(tbl[i].name, tbl[i].e_alm, tbl[i].e_slack, tbl[i].e_err);
    end

    // Hand sequence: reach CLOSED, saturate slack, then reset mid-CLOSED.
    step(1, 0, 0, 0, 0, 0); chk("seq_reset", 1, 0, 0);
    step(0, 0, 0, 0, 0, 0); chk("seq_open", 0, 0, 0);
    step(0, 0, 0, 0, 0, 1); chk("seq_fiu_close", 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0, 0, 0); chk("seq_slack", 1, i, 0);
    end
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 1, 0, 0, 0); chk("seq_slack_sat", 1, (8 + i > 15) ? 15 : 8 + i, 1);
    end
    step(0, 0, 0, 0, 0, 1); chk("seq_err_sticky", 1, 15, 1);
    step(1, 1, 3, 40, 30, 1); chk("seq_reset_mid_closed", 1, 0, 0);
    step(0, 1, 0, 40, 30, 1); chk("seq_after_reset", 1, 1, 1);

    // Randomized run against the model.
    step(1, 0, 0, 0, 0, 0);
    model(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      bit rst, vld, fiu;
      int len, a, f;
      rst = ($urandom_range(0, 99) < 3);
      vld = ($urandom_range(0, 99) < 45);
      fiu = ($urandom_range(0, 99) < 8);
      len = $urandom_range(0, 3);
      a   = $urandom_range(0, 40);
      f   = ($urandom_range(0, 99) < 4) ? $urandom_range(20, 60) : $urandom_range(0, 20);
      step(rst, vld, len, a, f, fiu);
      model(rst, vld, len, a, f, fiu);
      chk("random", m_alm, m_slack, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
